fir_section_tdm: RTL

Parametrised successor FIR section for the IIR filter datapath. It implements an odd-length, even-symmetric FIR (numerator) section with run-time programmable coefficients. The section uses a single time-multiplexed pre-add/multiply/accumulate unit and a valid/ready input handshake. It sits between the input sample source and the recursive (denominator) section, and produces one full-precision, rounded, saturated output per accepted sample.

---
 rtl/fir_section_tdm.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/fir_section_tdm.sv
// fir_section_tdm
//
// Odd-length, even-symmetric FIR section with programmable coefficients,
// built around one time-multiplexed pre-add / multiply / accumulate unit.
// Each accepted sample takes NUNIQ MAC cycles plus one output cycle. The
// result is rounded, saturated and then held on out_data.
//
// Ports
//   clk           clock
//   reset         asynchronous, active-high
//   enb           clock enable for FSM, accumulator and delay line
//   flush         synchronous clear of the delay line; aborts a computation
//   in_valid      input sample valid
//   in_data       signed input sample (DATA_W)
//   in_ready      high while idle; a sample is accepted on enb & in_valid & in_ready & !flush
//   coef_wr_en    shadow coefficient write strobe (works regardless of enb)
//   coef_wr_addr  unique-coefficient index k (weights taps k and TAPS-1-k)
//   coef_wr_data  signed coefficient (COEF_W)
//   out_valid     single-cycle pulse marking a new out_data
//   out_data      signed rounded and saturated result (OUT_W), held
//   out_sat       high when out_data was clipped
//   busy          high during MAC and OUT states
module fir_section_tdm #(
   parameter int DATA_W    = 11,
   parameter int COEF_W    = 12,
   parameter int TAPS      = 7,
   parameter int ACC_W     = 26,
   parameter int OUT_W     = 22,
   parameter int OUT_SHIFT = 0,
   localparam int NUNIQ    = (TAPS + 1) / 2,
   localparam int ADDR_W   = (NUNIQ > 1) ? $clog2(NUNIQ) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enb,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   input  logic              coef_wr_en,
   input  logic [ADDR_W-1:0] coef_wr_addr,
   input  logic [COEF_W-1:0] coef_wr_data,
   output logic              out_valid,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_sat,
   output logic              busy
);

   localparam int PRE_W   = DATA_W + 1;
   localparam int PROD_W  = PRE_W + COEF_W;
   localparam int ACCX_W  = ACC_W + 1;
   localparam int SAT_W   = (ACCX_W > OUT_W) ? ACCX_W : OUT_W;
   localparam int RND_POS = (OUT_SHIFT > 0) ? OUT_SHIFT - 1 : 0;

   localparam logic signed [ACCX_W-1:0] RND_ADD =
      (OUT_SHIFT > 0) ? (ACCX_W'(1) <<< RND_POS) : '0;
   localparam logic signed [SAT_W-1:0] SAT_MAX = SAT_W'({1'b0, {(OUT_W-1){1'b1}}});
   localparam logic signed [SAT_W-1:0] SAT_MIN = ~SAT_MAX;

   // Elaboration-time guards: the accumulator must never wrap and the
   // symmetric folding needs an odd tap count.
   if (ACC_W < DATA_W + 1 + COEF_W + $clog2(NUNIQ)) begin : g_acc_w_check
      $error("fir_section_tdm: ACC_W too small for DATA_W, COEF_W and TAPS");
   end
   if ((TAPS < 3) || (TAPS % 2 == 0)) begin : g_taps_check
      $error("fir_section_tdm: TAPS must be odd and at least 3");
   end

   // Round half up at the OUT_SHIFT boundary, then arithmetic shift.
   // One guard bit keeps the rounding addition from wrapping.
   function automatic logic signed [ACCX_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
      logic signed [ACCX_W-1:0] t;
      t = ACCX_W'(a) + RND_ADD;
      return t >>> OUT_SHIFT;
   endfunction

   // Clip to the OUT_W signed range; the MSB of the result is the clip flag.
   function automatic logic [OUT_W:0] saturate(input logic signed [SAT_W-1:0] v);
      if (v > SAT_MAX)
         return {1'b1, SAT_MAX[OUT_W-1:0]};
      else if (v < SAT_MIN)
         return {1'b1, SAT_MIN[OUT_W-1:0]};
      else
         return {1'b0, v[OUT_W-1:0]};
   endfunction

   typedef enum logic [1:0] {S_IDLE, S_MAC, S_OUT} state_t;

   state_t state, state_nxt;

   logic signed [DATA_W-1:0] x         [TAPS];
   logic signed [COEF_W-1:0] coef_shad [NUNIQ];
   logic signed [COEF_W-1:0] coef_act  [NUNIQ];
   logic signed [ACC_W-1:0]  acc;
   logic [ADDR_W-1:0]        step;

   logic                     accept;
   logic                     mac_step;
   logic                     out_step;
   logic                     last_step;
   logic                     coef_wr_hit;

   logic signed [PRE_W-1:0]  pre_sum;
   logic signed [COEF_W-1:0] coef_sel;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACCX_W-1:0] rnd;
   logic [OUT_W:0]           sat_res;

   assign coef_wr_hit = coef_wr_en && (int'(coef_wr_addr) < NUNIQ);
   assign last_step   = (step == ADDR_W'(NUNIQ - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      mac_step  = 1'b0;
      out_step  = 1'b0;
      in_ready  = (state == S_IDLE);
      busy      = (state != S_IDLE);
      if (enb) begin
         if (flush) begin
            state_nxt = S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (in_valid) begin
                     accept    = 1'b1;
                     state_nxt = S_MAC;
                  end
               end
               S_MAC: begin
                  mac_step = 1'b1;
                  if (last_step)
                     state_nxt = S_OUT;
               end
               S_OUT: begin
                  out_step  = 1'b1;
                  state_nxt = S_IDLE;
               end
               default: state_nxt = S_IDLE;
            endcase
         end
      end
   end

   // MAC operand select: folded tap pair for k < NUNIQ-1, centre tap alone last.
   always_comb begin
      pre_sum  = '0;
      coef_sel = '0;
      for (int k = 0; k < NUNIQ; k++) begin
         if (step == ADDR_W'(k)) begin
            if (k == NUNIQ - 1)
               pre_sum = PRE_W'(x[k]);
            else
               pre_sum = PRE_W'(x[k]) + PRE_W'(x[TAPS-1-k]);
            coef_sel = coef_act[k];
         end
      end
   end

   assign prod    = PROD_W'(pre_sum) * PROD_W'(coef_sel);
   assign rnd     = round_shift(acc);
   assign sat_res = saturate(SAT_W'(rnd));

   // Shadow coefficient bank: written in any cycle, independent of enb.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int k = 0; k < NUNIQ; k++)
            coef_shad[k] <= '0;
      end else if (coef_wr_hit) begin
         coef_shad[coef_wr_addr] <= coef_wr_data;
      end
   end

   // Accept stage: shift delay line, snapshot coefficients, clear accumulator.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < TAPS; i++)
            x[i] <= '0;
         for (int k = 0; k < NUNIQ; k++)
            coef_act[k] <= '0;
         acc  <= '0;
         step <= '0;
      end else if (enb && flush) begin
         for (int i = 0; i < TAPS; i++)
            x[i] <= '0;
         acc <= '0;
      end else if (accept) begin
         x[0] <= in_data;
         for (int i = 1; i < TAPS; i++)
            x[i] <= x[i-1];
         // A write landing in the accept cycle is already visible here.
         for (int k = 0; k < NUNIQ; k++)
            coef_act[k] <= (coef_wr_hit && (coef_wr_addr == ADDR_W'(k))) ? coef_wr_data
                                                                         : coef_shad[k];
         acc  <= '0;
         step <= '0;
      // MAC stage: one folded product per enabled cycle.
      end else if (mac_step) begin
         acc  <= acc + ACC_W'(prod);
         step <= step + 1'b1;
      end
   end

   // Output stage: round, saturate and hold; out_valid drops on the next clk regardless of enb.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         out_valid <= out_step;
         if (out_step) begin
            out_data <= sat_res[OUT_W-1:0];
            out_sat  <= sat_res[OUT_W];
         end
      end
   end

endmodule
